// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
//  if_id_queue : circular-buffer queue between instruction fetch and decode,
//                flushed on branch mispredict; empty head reads as all-zero.
//  Revision    : 1.0
// ============================================================================
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     branch_error,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [INST_W-1:0]        in_inst,
  input  logic                     in_predict,
  input  logic [ADDR_W-1:0]        in_next_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [INST_W-1:0]        out_inst,
  output logic                     out_predict,
  output logic [ADDR_W-1:0]        out_next_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic              r_pred_mem [DEPTH];
  logic [ADDR_W-1:0] r_npc_mem  [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_enq;
  logic              w_deq;

  // in_ready deliberately ignores out_ready: a full queue never accepts.
  assign in_ready  = (r_count < c_depth_cnt);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_enq = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;

  // Storage is not reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]   <= in_pc;
      r_inst_mem[r_wr_ptr] <= in_inst;
      r_pred_mem[r_wr_ptr] <= in_predict;
      r_npc_mem[r_wr_ptr]  <= in_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_error) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bubble outputs are forced to zero so ID sees a NOP word.
  always_comb begin
    out_pc      = '0;
    out_inst    = '0;
    out_predict = 1'b0;
    out_next_pc = '0;
    if (out_valid) begin
      out_pc      = r_pc_mem[r_rd_ptr];
      out_inst    = r_inst_mem[r_rd_ptr];
      out_predict = r_pred_mem[r_rd_ptr];
      out_next_pc = r_npc_mem[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
//  tb_if_id_queue : directed vector table, corner sequences and a random run
//                   against a queue reference model for if_id_queue.
//  Revision       : 1.0
// ============================================================================
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              branch_error = 1'b0;
  logic              in_valid = 1'b0;
  logic [ADDR_W-1:0] in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              in_predict = 1'b0;
  logic [ADDR_W-1:0] in_next_pc = '0;
  logic              in_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_predict;
  logic [ADDR_W-1:0] out_next_pc;
  logic              out_ready = 1'b0;
  logic [2:0]        count;

  int n_pass  = 0;
  int n_total = 0;

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .branch_error(branch_error),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_predict(in_predict), .in_next_pc(in_next_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_predict(out_predict), .out_next_pc(out_next_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Other entry fields are derived from pc so a pc alone identifies an entry.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h00500093 ^ ((pc ^ 32'h100) << 12);
  endfunction
  function automatic logic pred_of(input logic [31:0] pc);
    return pc[2];
  endfunction
  function automatic logic [31:0] npc_of(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  typedef struct {
    logic        rst;
    logic        be;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;
    int          exp_cnt;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic v,
                              input logic o, input logic [31:0] p,
                              input int c, input logic [31:0] hp);
    vec_t t;
    t.rst = r; t.be = b; t.iv = v; t.ordy = o; t.pc = p;
    t.exp_cnt = c; t.exp_pc = hp;
    return t;
  endfunction

  task automatic drive(input logic r, input logic b, input logic v,
                       input logic o, input logic [31:0] p);
    rst = r; branch_error = b; in_valid = v; out_ready = o;
    in_pc = p; in_inst = inst_of(p); in_predict = pred_of(p);
    in_next_pc = npc_of(p);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected outputs follow from the expected count and head pc alone.
  task automatic check_state(input string name, input int exp_cnt,
                             input logic [31:0] exp_pc);
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_pc, e_inst, e_npc;
    logic        e_pred;
    e_ov   = (exp_cnt != 0);
    e_ir   = (exp_cnt < DEPTH);
    e_pc   = e_ov ? exp_pc : 32'h0;
    e_inst = e_ov ? inst_of(exp_pc) : 32'h0;
    e_pred = e_ov ? pred_of(exp_pc) : 1'b0;
    e_npc  = e_ov ? npc_of(exp_pc) : 32'h0;
    n_total++;
    if (int'(count) == exp_cnt && out_valid == e_ov && in_ready == e_ir &&
        out_pc == e_pc && out_inst == e_inst && out_predict == e_pred &&
        out_next_pc == e_npc) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got cnt=%0d ov=%0b ir=%0b pc=%h inst=%h pr=%0b npc=%h; want cnt=%0d ov=%0b ir=%0b pc=%h inst=%h pr=%0b npc=%h",
               name, count, out_valid, in_ready, out_pc, out_inst, out_predict,
               out_next_pc, exp_cnt, e_ov, e_ir, e_pc, e_inst, e_pred, e_npc);
    end
  endtask

  vec_t        tbl[$];
  logic [31:0] mq[$];

  initial begin
    // Expected state is the state seen after the clock edge the vector drives.
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0));    // reset
    tbl.push_back(mk(0, 0, 1, 0, 32'h100, 1, 32'h100));  // first enqueue
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,   1, 32'h0));    // fill to full
    tbl.push_back(mk(0, 0, 1, 0, 32'h4,   2, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h8,   3, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'hC,   4, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h10,  4, 32'h0));    // dropped while full
    tbl.push_back(mk(0, 0, 1, 1, 32'h10,  3, 32'h4));    // full: dequeue only
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   2, 32'h8));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h0));    // drained, bubble
    tbl.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h0));    // no underflow
    tbl.push_back(mk(0, 0, 1, 0, 32'h20,  1, 32'h20));
    tbl.push_back(mk(0, 0, 1, 0, 32'h24,  2, 32'h20));
    tbl.push_back(mk(0, 0, 1, 0, 32'h28,  3, 32'h20));
    tbl.push_back(mk(0, 1, 1, 1, 32'h200, 0, 32'h0));    // flush drops 0x200
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h30,  1, 32'h30));
    tbl.push_back(mk(0, 0, 1, 0, 32'h34,  2, 32'h30));
    tbl.push_back(mk(1, 0, 1, 1, 32'h38,  0, 32'h0));    // reset wins
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 32'h40,  1, 32'h40));
    tbl.push_back(mk(1, 1, 1, 1, 32'h44,  0, 32'h0));    // reset with flush
    tbl.push_back(mk(0, 0, 1, 1, 32'h48,  1, 32'h48));   // enqueue into empty

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].be, tbl[i].iv, tbl[i].ordy, tbl[i].pc);
      step();
      check_state($sformatf("vec%0d", i), tbl[i].exp_cnt, tbl[i].exp_pc);
    end

    // Steady state at count 2 with simultaneous enqueue/dequeue and wrap.
    drive(1, 0, 0, 0, 32'h0); step();
    drive(0, 0, 1, 0, 32'h300); step();
    drive(0, 0, 1, 0, 32'h304); step();
    check_state("steady_fill", 2, 32'h300);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 1, 1, 32'h300 + 32'(4 * (k + 1)));
      step();
      check_state($sformatf("steady%0d", k), 2, 32'h300 + 32'(4 * k));
    end

    // Head holds while ID stalls.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 32'h0);
      step();
      check_state($sformatf("hold%0d", k), 2, 32'h328);
    end

    // Random traffic against a reference queue.
    drive(1, 0, 0, 0, 32'h0); step();
    mq.delete();
    for (int c = 0; c < 10000; c++) begin
      logic r, b, v, o;
      logic [31:0] p;
      int sz;
      r = ($urandom_range(0, 199) == 0);
      b = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      p = $urandom;
      drive(r, b, v, o, p);
      sz = mq.size();
      if (r || b) begin
        mq.delete();
      end else begin
        if (o && sz != 0) void'(mq.pop_front());
        if (v && sz < DEPTH) mq.push_back(p);
      end
      step();
      check_state($sformatf("rand%0d", c), mq.size(),
                  (mq.size() != 0) ? mq[0] : 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
